// File: rtl/pipelined_segment_adder.sv
// Pipelined add/subtract: N bits split into SEGMENTS slices, one slice per stage, carry registered.
// Optional signed-overflow output enabled by PIPELINED_SEGMENT_ADDER_OVERFLOW_EN.
module pipelined_segment_adder #(
  parameter int unsigned N        = 32,
  parameter int unsigned SEGMENTS = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         carry_in,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] c,
  output logic         carry_out
`ifdef PIPELINED_SEGMENT_ADDER_OVERFLOW_EN
  ,
  output logic         overflow
`endif
);

  localparam int unsigned W = N / SEGMENTS;

  if (SEGMENTS == 0 || (N % SEGMENTS) != 0) begin : g_param_check
    $error("pipelined_segment_adder: N must be a nonzero multiple of SEGMENTS");
  end

  logic advance;

  // Registered state of every stage, exposed as arrays so stage k can read stage k-1.
  logic [N-1:0]        stage_sum   [SEGMENTS];
  logic [N-1:0]        stage_a     [SEGMENTS];
  logic [N-1:0]        stage_bb    [SEGMENTS];
  logic [SEGMENTS-1:0] stage_carry;
  logic [SEGMENTS-1:0] stage_valid;

  // Global stall: every stage moves only when the output slot is free or being drained.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < SEGMENTS; k++) begin : g_stage
    logic [N-1:0] src_a;
    logic [N-1:0] src_bb;
    logic [N-1:0] src_sum;
    logic         src_c;
    logic         src_v;
    logic [W:0]   slice;
    logic [N-1:0] sum_d;

    logic [N-1:0] sum_q;
    logic [N-1:0] a_q;
    logic [N-1:0] bb_q;
    logic         carry_q;
    logic         valid_q;

    if (k == 0) begin : g_head
      assign src_a   = a;
      assign src_bb  = b ^ {N{sub}};
      assign src_c   = carry_in ^ sub;
      assign src_sum = '0;
      assign src_v   = in_valid;
    end else begin : g_tail
      assign src_a   = stage_a[k-1];
      assign src_bb  = stage_bb[k-1];
      assign src_c   = stage_carry[k-1];
      assign src_sum = stage_sum[k-1];
      assign src_v   = stage_valid[k-1];
    end

    assign slice = {1'b0, src_a[k*W +: W]} + {1'b0, src_bb[k*W +: W]} + {{W{1'b0}}, src_c};

    always_comb begin
      sum_d            = src_sum;
      sum_d[k*W +: W]  = slice[W-1:0];
    end

    // Data only loads with a valid operand, so c reads 0 until the first real result.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        sum_q   <= '0;
        a_q     <= '0;
        bb_q    <= '0;
        carry_q <= 1'b0;
      end else if (advance) begin
        valid_q <= src_v;
        if (src_v) begin
          sum_q   <= sum_d;
          a_q     <= src_a;
          bb_q    <= src_bb;
          carry_q <= slice[W];
        end
      end
    end

    assign stage_sum[k]   = sum_q;
    assign stage_a[k]     = a_q;
    assign stage_bb[k]    = bb_q;
    assign stage_carry[k] = carry_q;
    assign stage_valid[k] = valid_q;

`ifdef PIPELINED_SEGMENT_ADDER_OVERFLOW_EN
    if (k == SEGMENTS - 1) begin : g_ovf
      logic ovf_q;
      logic msb_carry_in;

      // Carry into bit N-1 recovered from the sum bit: s = a ^ bb ^ cin.
      assign msb_carry_in = src_a[N-1] ^ src_bb[N-1] ^ slice[W-1];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (advance && src_v) begin
          ovf_q <= msb_carry_in ^ slice[W];
        end
      end

      assign overflow = ovf_q;
    end
`endif
  end

  assign out_valid = stage_valid[SEGMENTS-1];
  assign c         = stage_sum[SEGMENTS-1];
  assign carry_out = stage_carry[SEGMENTS-1];

endmodule

// File: tb/tb_pipelined_segment_adder.sv
// Directed bench for pipelined_segment_adder: latency, add/sub, stream, stall, reset, N=8 sweep.
module tb_pipelined_segment_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic        carry_in, sub, carry_out;
  logic [31:0] a, b, c;
`ifdef PIPELINED_SEGMENT_ADDER_OVERFLOW_EN
  logic        overflow;
  logic        ovf1, ovf2, ovf8;
`endif

  logic       in_valid8, carry_in8, sub8, out_ready8;
  logic [7:0] a8, b8;
  logic       ir1, ir2, ir8, ov1, ov2, ov8, co1, co2, co8;
  logic [7:0] c1, c2, c8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipelined_segment_adder #(.N(32), .SEGMENTS(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .carry_in(carry_in), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .c(c),
    .carry_out(carry_out)
`ifdef PIPELINED_SEGMENT_ADDER_OVERFLOW_EN
    , .overflow(overflow)
`endif
  );

  pipelined_segment_adder #(.N(8), .SEGMENTS(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(ir1), .a(a8), .b(b8),
    .carry_in(carry_in8), .sub(sub8), .out_valid(ov1), .out_ready(out_ready8), .c(c1),
    .carry_out(co1)
`ifdef PIPELINED_SEGMENT_ADDER_OVERFLOW_EN
    , .overflow(ovf1)
`endif
  );

  pipelined_segment_adder #(.N(8), .SEGMENTS(2)) u_s2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(ir2), .a(a8), .b(b8),
    .carry_in(carry_in8), .sub(sub8), .out_valid(ov2), .out_ready(out_ready8), .c(c2),
    .carry_out(co2)
`ifdef PIPELINED_SEGMENT_ADDER_OVERFLOW_EN
    , .overflow(ovf2)
`endif
  );

  pipelined_segment_adder #(.N(8), .SEGMENTS(8)) u_s8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(ir8), .a(a8), .b(b8),
    .carry_in(carry_in8), .sub(sub8), .out_valid(ov8), .out_ready(out_ready8), .c(c8),
    .carry_out(co8)
`ifdef PIPELINED_SEGMENT_ADDER_OVERFLOW_EN
    , .overflow(ovf8)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [32:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic ci, input logic s);
    logic [31:0] yy;
    yy = s ? ~y : y;
    return {1'b0, x} + {1'b0, yy} + {32'd0, ci ^ s};
  endfunction

  function automatic logic model_ovf(input logic [31:0] x, input logic [31:0] y, input logic s,
                                     input logic [31:0] r);
    logic [31:0] yy;
    yy = s ? ~y : y;
    return (x[31] == yy[31]) && (r[31] != x[31]);
  endfunction

  // Directed vectors with hand-computed results.
  logic [31:0] da [6] = '{32'd5, 32'd7, 32'd1, 32'd10, 32'h8000_0000, 32'h7FFF_FFFF};
  logic [31:0] db [6] = '{32'd7, 32'd5, 32'd2, 32'd3, 32'd1, 32'd1};
  logic        dci[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic        dsb[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [31:0] ec [6] = '{32'hFFFF_FFFE, 32'd2, 32'd4, 32'd6, 32'h7FFF_FFFF, 32'h8000_0000};
  logic        eco[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic        eov[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  logic [32:0] exp_q [$];
  logic        exp_ov_q [$];

  initial begin
    int got;
    logic [32:0] e;
    logic        eo;
    logic [31:0] ra, rb;
    logic        rci, rsb;

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; carry_in = 1'b0; sub = 1'b0;
    out_ready = 1'b1;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; carry_in8 = 1'b0; sub8 = 1'b0; out_ready8 = 1'b1;

    // Reset state
    #12;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_c", c, 32'd0);
    check("rst_carry_out", carry_out, 1'b0);
`ifdef PIPELINED_SEGMENT_ADDER_OVERFLOW_EN
    check("rst_overflow", overflow, 1'b0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_rst_in_ready", in_ready, 1'b1);
    check("post_rst_out_valid", out_valid, 1'b0);

    // Single add with full carry ripple, latency 4
    a = 32'hFFFF_FFFF; b = 32'h1; carry_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      in_valid = 1'b0;
      if (i < 4) check("lat_add_early_valid", out_valid, 1'b0);
    end
    check("add_out_valid", out_valid, 1'b1);
    check("add_c", c, 32'h0);
    check("add_carry_out", carry_out, 1'b1);
    step();
    check("add_consumed", out_valid, 1'b0);

    // Directed add/sub stream
    got = 0;
    for (int i = 0; i < 12; i++) begin
      if (i < 6) begin
        a = da[i]; b = db[i]; carry_in = dci[i]; sub = dsb[i]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (out_valid) begin
        check("dir_c", c, ec[got]);
        check("dir_carry_out", carry_out, eco[got]);
`ifdef PIPELINED_SEGMENT_ADDER_OVERFLOW_EN
        check("dir_overflow", overflow, eov[got]);
`endif
        got++;
      end
    end
    check("dir_count", got, 6);

    // Random back-to-back stream against the model
    got = 0;
    for (int i = 0; i < 110; i++) begin
      if (out_valid) begin
        e  = exp_q.pop_front();
        eo = exp_ov_q.pop_front();
        check("rnd_c", c, e[31:0]);
        check("rnd_carry_out", carry_out, e[32]);
`ifdef PIPELINED_SEGMENT_ADDER_OVERFLOW_EN
        check("rnd_overflow", overflow, eo);
`endif
        got++;
      end
      if (i < 100) begin
        ra = $urandom; rb = $urandom; rci = 1'($urandom_range(1)); rsb = 1'($urandom_range(1));
        a = ra; b = rb; carry_in = rci; sub = rsb; in_valid = 1'b1;
        e = model(ra, rb, rci, rsb);
        exp_q.push_back(e);
        exp_ov_q.push_back(model_ovf(ra, rb, rsb, e[31:0]));
      end else begin
        in_valid = 1'b0;
      end
      step();
    end
    check("rnd_count", got, 100);

    // Backpressure: fill with out_ready low, stall 10 cycles, release
    out_ready = 1'b0; carry_in = 1'b0; sub = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = 32'd100 * (i + 1); b = i; in_valid = 1'b1;
      step();
    end
    a = 32'd500; b = 32'd4; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("stall_in_ready", in_ready, 1'b0);
      check("stall_out_valid", out_valid, 1'b1);
      check("stall_c", c, 32'd100);
      step();
    end
    check("stall_end_c", c, 32'd100);
    out_ready = 1'b1;
    #1;
    check("release_in_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    check("bp_r1", c, 32'd201);
    check("bp_r1_valid", out_valid, 1'b1);
    step();
    check("bp_r2", c, 32'd302);
    step();
    check("bp_r3", c, 32'd403);
    step();
    check("bp_r4", c, 32'd504);
    check("bp_r4_valid", out_valid, 1'b1);
    step();
    check("bp_drained", out_valid, 1'b0);

    // Parameter sweep N=8: 0x7F + 0x01
    a8 = 8'h7F; b8 = 8'h01; in_valid8 = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      in_valid8 = 1'b0;
      check("sw1_valid", ov1, i == 1);
      check("sw2_valid", ov2, i == 2);
      check("sw8_valid", ov8, i == 8);
      if (i == 1) begin
        check("sw1_c", c1, 8'h80);
        check("sw1_co", co1, 1'b0);
      end
      if (i == 2) begin
        check("sw2_c", c2, 8'h80);
        check("sw2_co", co2, 1'b0);
      end
      if (i == 8) begin
        check("sw8_c", c8, 8'h80);
        check("sw8_co", co8, 1'b0);
      end
    end

    // Reset mid-stream with results in flight
    for (int i = 0; i < 4; i++) begin
      a = i + 1; b = 32'd1; in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    check("pre_rst_valid", out_valid, 1'b1);
    check("pre_rst_c", c, 32'd2);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 1'b0);
    check("async_rst_c", c, 32'd0);
    check("async_rst_co", carry_out, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("flush_valid", out_valid, 1'b0);
      check("flush_c", c, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
